mem_wb_pipe_reg: RTL and testbench
==================================

Name: mem_wb_pipe_reg

Overview:
- MEM/WB pipeline register of the 5-stage MIPS datapath.
- Captures the memory-stage data results and the write-back control bits on each rising clock edge.
- Presents them to the write-back stage exactly one cycle later.
- Pure storage: no arithmetic or decoding; every output is a registered copy of its input.

Parameters:
- DATA_W, 32, width of the data paths (read data, HI, LO, zero/compare value, ALU result).
- REG_ADDR_W, 5, width of the destination register address. A 4-bit value connected to this port is zero-extended.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- RegWriteIn  in  1  register-file write enable from MEM.
- MoveNotZeroIn  in  1  conditional move (movn/movz) select.
- DontMoveIn  in  1  suppress conditional move.
- HiOrLoIn  in  1  selects HI (1) or LO (0) for write-back.
- MemToRegIn  in  1  write-back source is memory read data.
- HiLoToRegIn  in  1  write-back source is HI/LO.
- RHiIn  in  DATA_W  HI register value.
- RLoIn  in  DATA_W  LO register value.
- ZeroIn  in  DATA_W  zero/compare operand for conditional moves.
- ALUResultIn  in  DATA_W  ALU result.
- WriteAddressIn  in  REG_ADDR_W  destination register number.
- ReadDataIn  in  DATA_W  data-memory read data.
- RegWriteOut, MoveNotZeroOut, DontMoveOut, HiOrLoOut, MemToRegOut, HiLoToRegOut  out  1 each  registered copies of the matching inputs.
- RHiOut, RLoOut, ZeroOut, ALUResultOut, ReadDataOut  out  DATA_W  registered copies.
- WriteAddressOut  out  REG_ADDR_W  registered copy.

Behaviour:
- All outputs are driven directly from flip-flops. There is no combinational path from any input to any output.
- On a rising Clk edge with Reset=1: every output becomes 0, control and data alike. A cleared register is a bubble (RegWriteOut=0).
- On a rising Clk edge with Reset=0: every output takes the value its input held just before the edge.
- Latency is exactly 1 cycle; throughput is 1 transfer per cycle.
- No handshake and no state machine.
- Reset asserted mid-stream: the value captured on that edge is discarded; outputs are 0 from that edge onward while Reset=1. Capture resumes on the first edge with Reset=0.
- Fields are independent. Changing one input affects only its own output; all other outputs hold their previously captured values.
- Input changes between edges are not visible on outputs until the next rising edge.
- Widths are preserved bit-for-bit: no sign extension and no truncation.

Optional Feature:
- Macro: MEM_WB_STALL_EN.
- Defined: adds input port Stall (1 bit, active-high), placed after Reset.
  - Rising edge with Stall=1 and Reset=0: all outputs hold their current values.
  - Reset has priority over Stall.
- Undefined: no Stall port; the register captures on every edge.

Decomposition:
- Shared package mips_pkg holds the constants DATA_W=32 and REG_ADDR_W=5. Parameter defaults are taken from it.
- One sub-module, pipe_reg: a generic width-parameterized register with synchronous active-high reset to 0 and a hold enable.
  - Instantiated once per field, or once over the concatenated bus.
  - The enable is tied to 1 when MEM_WB_STALL_EN is not defined.

Test Plan:
- Reset: drive all inputs to all-ones with Reset=1 for one edge -> every output reads 0 after the edge.
- Per-field capture: with all inputs 0, set ReadDataIn=32'hFFFFFFFF -> ReadDataOut=32'hFFFFFFFF at the next negedge, all other outputs still 0. Repeat separately for RHiIn, RLoIn, ZeroIn, ALUResultIn, and WriteAddressIn=5'h0F.
- Control bits: assert RegWriteIn, MoveNotZeroIn, DontMoveIn, HiOrLoIn, MemToRegIn, HiLoToRegIn one at a time -> each matching output reads 1 exactly one edge later, and earlier-set outputs stay 1.
- Latency: change ALUResultIn 32'h0 -> 32'h12345678 -> 32'hDEADBEEF on consecutive edges -> ALUResultOut follows the same sequence delayed by one cycle. A mid-cycle input change is not visible before the next edge.
- Reset mid-operation: with outputs holding nonzero values, assert Reset for one edge -> all outputs 0. Deassert Reset -> capture of current inputs resumes on the following edge.
- (MEM_WB_STALL_EN defined) Stall=1 while ReadDataIn changes 32'h1 -> 32'h2 -> ReadDataOut holds 32'h1. Then Stall=1 together with Reset=1 -> outputs become 0.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared datapath constants and write-back control bundle
//
// Purpose: widths used across the MIPS datapath pipeline registers, plus the
//          packed write-back control group carried from MEM to WB.
// Contents:
//   DATA_W     - width of data paths (read data, HI, LO, zero, ALU result)
//   REG_ADDR_W - width of a register-file address
//   wbCtrl_t   - packed write-back control bits, MSB first as listed
//   WB_CTRL_W  - width of wbCtrl_t

package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic RegWrite;
        logic MoveNotZero;
        logic DontMove;
        logic HiOrLo;
        logic MemToReg;
        logic HiLoToReg;
    } wbCtrl_t;

    localparam int WB_CTRL_W = $bits(wbCtrl_t);

endpackage

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - generic width-parameterized pipeline register
//
// Purpose: WIDTH-bit register with synchronous active-high clear and a
//          capture enable; Enable=0 holds the current value.
// Ports:
//   Clk    in  1      rising-edge clock
//   Reset  in  1      synchronous active-high clear to 0 (beats Enable)
//   Enable in  1      capture D when 1, hold when 0
//   D      in  WIDTH  next value
//   Q      out WIDTH  registered value

module pipe_reg #(
    parameter int WIDTH = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Enable,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Q <= '0;
        end else if (Enable) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// rtl/mem_wb_pipe_reg.sv - MEM/WB pipeline register of the 5-stage MIPS datapath
//
// Purpose: captures memory-stage data results and write-back control bits on
//          each rising Clk edge and presents them to write-back one cycle
//          later. Every output comes straight from a flip-flop.
// Build option: MEM_WB_STALL_EN adds the Stall input (after Reset); with
//          Stall=1 and Reset=0 all outputs hold. Reset beats Stall.
// Ports:
//   Clk, Reset                  in  1           clock, synchronous active-high clear
//   Stall                       in  1           hold request (MEM_WB_STALL_EN only)
//   RegWriteIn .. HiLoToRegIn   in  1 each      write-back control bits
//   RHiIn, RLoIn, ZeroIn,
//   ALUResultIn, ReadDataIn     in  DATA_W      data results
//   WriteAddressIn              in  REG_ADDR_W  destination register
//   *Out                        out             registered copies of the above

module mem_wb_pipe_reg
    import mips_pkg::*;
#(
    parameter int DATA_W     = mips_pkg::DATA_W,
    parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
    input  logic                  Clk,
    input  logic                  Reset,
`ifdef MEM_WB_STALL_EN
    input  logic                  Stall,
`endif
    input  logic                  RegWriteIn,
    input  logic                  MoveNotZeroIn,
    input  logic                  DontMoveIn,
    input  logic                  HiOrLoIn,
    input  logic                  MemToRegIn,
    input  logic                  HiLoToRegIn,
    input  logic [DATA_W-1:0]     RHiIn,
    input  logic [DATA_W-1:0]     RLoIn,
    input  logic [DATA_W-1:0]     ZeroIn,
    input  logic [DATA_W-1:0]     ALUResultIn,
    input  logic [REG_ADDR_W-1:0] WriteAddressIn,
    input  logic [DATA_W-1:0]     ReadDataIn,
    output logic                  RegWriteOut,
    output logic                  MoveNotZeroOut,
    output logic                  DontMoveOut,
    output logic                  HiOrLoOut,
    output logic                  MemToRegOut,
    output logic                  HiLoToRegOut,
    output logic [DATA_W-1:0]     RHiOut,
    output logic [DATA_W-1:0]     RLoOut,
    output logic [DATA_W-1:0]     ZeroOut,
    output logic [DATA_W-1:0]     ALUResultOut,
    output logic [REG_ADDR_W-1:0] WriteAddressOut,
    output logic [DATA_W-1:0]     ReadDataOut
);

    logic captureEn;

`ifdef MEM_WB_STALL_EN
    assign captureEn = ~Stall;
`else
    assign captureEn = 1'b1;
`endif

    // Control bits travel as one packed group; a cleared group is a bubble.
    wbCtrl_t ctrlIn;
    wbCtrl_t ctrlOut;

    always_comb begin
        ctrlIn             = '0;
        ctrlIn.RegWrite    = RegWriteIn;
        ctrlIn.MoveNotZero = MoveNotZeroIn;
        ctrlIn.DontMove    = DontMoveIn;
        ctrlIn.HiOrLo      = HiOrLoIn;
        ctrlIn.MemToReg    = MemToRegIn;
        ctrlIn.HiLoToReg   = HiLoToRegIn;
    end

    pipe_reg #(.WIDTH(WB_CTRL_W)) uCtrl (
        .Clk(Clk), .Reset(Reset), .Enable(captureEn),
        .D(ctrlIn), .Q(ctrlOut)
    );

    assign RegWriteOut    = ctrlOut.RegWrite;
    assign MoveNotZeroOut = ctrlOut.MoveNotZero;
    assign DontMoveOut    = ctrlOut.DontMove;
    assign HiOrLoOut      = ctrlOut.HiOrLo;
    assign MemToRegOut    = ctrlOut.MemToReg;
    assign HiLoToRegOut   = ctrlOut.HiLoToReg;

    pipe_reg #(.WIDTH(DATA_W)) uRHi (
        .Clk(Clk), .Reset(Reset), .Enable(captureEn),
        .D(RHiIn), .Q(RHiOut)
    );

    pipe_reg #(.WIDTH(DATA_W)) uRLo (
        .Clk(Clk), .Reset(Reset), .Enable(captureEn),
        .D(RLoIn), .Q(RLoOut)
    );

    pipe_reg #(.WIDTH(DATA_W)) uZero (
        .Clk(Clk), .Reset(Reset), .Enable(captureEn),
        .D(ZeroIn), .Q(ZeroOut)
    );

    pipe_reg #(.WIDTH(DATA_W)) uALUResult (
        .Clk(Clk), .Reset(Reset), .Enable(captureEn),
        .D(ALUResultIn), .Q(ALUResultOut)
    );

    pipe_reg #(.WIDTH(REG_ADDR_W)) uWriteAddress (
        .Clk(Clk), .Reset(Reset), .Enable(captureEn),
        .D(WriteAddressIn), .Q(WriteAddressOut)
    );

    pipe_reg #(.WIDTH(DATA_W)) uReadData (
        .Clk(Clk), .Reset(Reset), .Enable(captureEn),
        .D(ReadDataIn), .Q(ReadDataOut)
    );

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// tb/tb_mem_wb_pipe_reg.sv - self-checking bench for mem_wb_pipe_reg

module tb_mem_wb_pipe_reg;

    typedef struct {
        logic [5:0]  ctrl;   // RegWrite,MoveNotZero,DontMove,HiOrLo,MemToReg,HiLoToReg
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] zero;
        logic [31:0] alu;
        logic [4:0]  wa;
        logic [31:0] rd;
    } fields_t;

    typedef struct {
        string   name;
        logic    rst;
        fields_t in;
        fields_t exp;
    } vec_t;

    logic        Clk = 1'b0;
    logic        Reset;
`ifdef MEM_WB_STALL_EN
    logic        Stall;
`endif
    logic        RegWriteIn, MoveNotZeroIn, DontMoveIn, HiOrLoIn, MemToRegIn, HiLoToRegIn;
    logic [31:0] RHiIn, RLoIn, ZeroIn, ALUResultIn, ReadDataIn;
    logic [4:0]  WriteAddressIn;
    logic        RegWriteOut, MoveNotZeroOut, DontMoveOut, HiOrLoOut, MemToRegOut, HiLoToRegOut;
    logic [31:0] RHiOut, RLoOut, ZeroOut, ALUResultOut, ReadDataOut;
    logic [4:0]  WriteAddressOut;

    int compared = 0;
    int mismatched = 0;
    vec_t vecs[$];

    always #5 Clk = ~Clk;

    mem_wb_pipe_reg dut (
        .Clk(Clk),
        .Reset(Reset),
`ifdef MEM_WB_STALL_EN
        .Stall(Stall),
`endif
        .RegWriteIn(RegWriteIn),
        .MoveNotZeroIn(MoveNotZeroIn),
        .DontMoveIn(DontMoveIn),
        .HiOrLoIn(HiOrLoIn),
        .MemToRegIn(MemToRegIn),
        .HiLoToRegIn(HiLoToRegIn),
        .RHiIn(RHiIn),
        .RLoIn(RLoIn),
        .ZeroIn(ZeroIn),
        .ALUResultIn(ALUResultIn),
        .WriteAddressIn(WriteAddressIn),
        .ReadDataIn(ReadDataIn),
        .RegWriteOut(RegWriteOut),
        .MoveNotZeroOut(MoveNotZeroOut),
        .DontMoveOut(DontMoveOut),
        .HiOrLoOut(HiOrLoOut),
        .MemToRegOut(MemToRegOut),
        .HiLoToRegOut(HiLoToRegOut),
        .RHiOut(RHiOut),
        .RLoOut(RLoOut),
        .ZeroOut(ZeroOut),
        .ALUResultOut(ALUResultOut),
        .WriteAddressOut(WriteAddressOut),
        .ReadDataOut(ReadDataOut)
    );

    function automatic fields_t mk(logic [5:0] c, logic [31:0] h, logic [31:0] l,
                                   logic [31:0] z, logic [31:0] a, logic [4:0] w,
                                   logic [31:0] r);
        fields_t f;
        f.ctrl = c; f.hi = h; f.lo = l; f.zero = z; f.alu = a; f.wa = w; f.rd = r;
        return f;
    endfunction

    task automatic add(string n, logic r, fields_t i, fields_t e);
        vec_t v;
        v.name = n; v.rst = r; v.in = i; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic drive(fields_t f);
        {RegWriteIn, MoveNotZeroIn, DontMoveIn, HiOrLoIn, MemToRegIn, HiLoToRegIn} = f.ctrl;
        RHiIn = f.hi; RLoIn = f.lo; ZeroIn = f.zero; ALUResultIn = f.alu;
        WriteAddressIn = f.wa; ReadDataIn = f.rd;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(string nm, fields_t e);
        chk({nm, ".ctrl"}, {26'd0, RegWriteOut, MoveNotZeroOut, DontMoveOut,
                            HiOrLoOut, MemToRegOut, HiLoToRegOut}, {26'd0, e.ctrl});
        chk({nm, ".RHi"}, RHiOut, e.hi);
        chk({nm, ".RLo"}, RLoOut, e.lo);
        chk({nm, ".Zero"}, ZeroOut, e.zero);
        chk({nm, ".ALUResult"}, ALUResultOut, e.alu);
        chk({nm, ".WriteAddress"}, {27'd0, WriteAddressOut}, {27'd0, e.wa});
        chk({nm, ".ReadData"}, ReadDataOut, e.rd);
    endtask

    // One edge: drive away from the edge, sample 1 time unit after it.
    task automatic step(logic r, fields_t i);
        @(negedge Clk);
        Reset = r;
        drive(i);
        @(posedge Clk);
        #1;
    endtask

    fields_t z0, ones, cur;

    initial begin
        z0   = mk(6'h00, 32'h0, 32'h0, 32'h0, 32'h0, 5'h00, 32'h0);
        ones = mk(6'h3F, '1, '1, '1, '1, 5'h1F, '1);
        Reset = 1'b1;
`ifdef MEM_WB_STALL_EN
        Stall = 1'b0;
`endif
        drive(z0);

        add("reset_all_ones", 1'b1, ones, z0);
        add("rd_only",   1'b0, mk(6'h00, 0, 0, 0, 0, 5'h00, 32'hFFFFFFFF),
                               mk(6'h00, 0, 0, 0, 0, 5'h00, 32'hFFFFFFFF));
        add("hi_only",   1'b0, mk(6'h00, 32'hFFFFFFFF, 0, 0, 0, 5'h00, 0),
                               mk(6'h00, 32'hFFFFFFFF, 0, 0, 0, 5'h00, 0));
        add("lo_only",   1'b0, mk(6'h00, 0, 32'hFFFFFFFF, 0, 0, 5'h00, 0),
                               mk(6'h00, 0, 32'hFFFFFFFF, 0, 0, 5'h00, 0));
        add("zero_only", 1'b0, mk(6'h00, 0, 0, 32'hFFFFFFFF, 0, 5'h00, 0),
                               mk(6'h00, 0, 0, 32'hFFFFFFFF, 0, 5'h00, 0));
        add("alu_only",  1'b0, mk(6'h00, 0, 0, 0, 32'hFFFFFFFF, 5'h00, 0),
                               mk(6'h00, 0, 0, 0, 32'hFFFFFFFF, 5'h00, 0));
        add("wa_0F",     1'b0, mk(6'h00, 0, 0, 0, 0, 5'h0F, 0),
                               mk(6'h00, 0, 0, 0, 0, 5'h0F, 0));
        add("wa_1F",     1'b0, mk(6'h00, 0, 0, 0, 0, 5'h1F, 0),
                               mk(6'h00, 0, 0, 0, 0, 5'h1F, 0));
        add("ctrl_regwrite",  1'b0, mk(6'h20, 0, 0, 0, 0, 5'h00, 0), mk(6'h20, 0, 0, 0, 0, 5'h00, 0));
        add("ctrl_movnz",     1'b0, mk(6'h30, 0, 0, 0, 0, 5'h00, 0), mk(6'h30, 0, 0, 0, 0, 5'h00, 0));
        add("ctrl_dontmove",  1'b0, mk(6'h38, 0, 0, 0, 0, 5'h00, 0), mk(6'h38, 0, 0, 0, 0, 5'h00, 0));
        add("ctrl_hiorlo",    1'b0, mk(6'h3C, 0, 0, 0, 0, 5'h00, 0), mk(6'h3C, 0, 0, 0, 0, 5'h00, 0));
        add("ctrl_memtoreg",  1'b0, mk(6'h3E, 0, 0, 0, 0, 5'h00, 0), mk(6'h3E, 0, 0, 0, 0, 5'h00, 0));
        add("ctrl_hilotoreg", 1'b0, mk(6'h3F, 0, 0, 0, 0, 5'h00, 0), mk(6'h3F, 0, 0, 0, 0, 5'h00, 0));
        add("lat_alu0",    1'b0, mk(6'h3F, 0, 0, 0, 32'h00000000, 5'h00, 0), mk(6'h3F, 0, 0, 0, 32'h00000000, 5'h00, 0));
        add("lat_alu1234", 1'b0, mk(6'h3F, 0, 0, 0, 32'h12345678, 5'h00, 0), mk(6'h3F, 0, 0, 0, 32'h12345678, 5'h00, 0));
        add("lat_aludead", 1'b0, mk(6'h3F, 0, 0, 0, 32'hDEADBEEF, 5'h00, 0), mk(6'h3F, 0, 0, 0, 32'hDEADBEEF, 5'h00, 0));
        add("mixed", 1'b0, mk(6'h15, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h80000000, 32'h00000001, 5'h11, 32'hCAFEF00D),
                           mk(6'h15, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h80000000, 32'h00000001, 5'h11, 32'hCAFEF00D));
        add("reset_mid", 1'b1, mk(6'h2A, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 5'h05, 32'h55555555), z0);
        add("resume",    1'b0, mk(6'h2A, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 5'h05, 32'h55555555),
                               mk(6'h2A, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 5'h05, 32'h55555555));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].in);
            chk_all(vecs[i].name, vecs[i].exp);
        end

        // Mid-cycle input change stays invisible until the next edge.
        cur = mk(6'h3F, 0, 0, 0, 32'h0000AAAA, 5'h03, 0);
        step(1'b0, cur);
        chk("midcyc_capture", ALUResultOut, 32'h0000AAAA);
        ALUResultIn = 32'h0000BBBB;
        #3;
        chk("midcyc_hidden", ALUResultOut, 32'h0000AAAA);
        @(posedge Clk);
        #1;
        chk("midcyc_next_edge", ALUResultOut, 32'h0000BBBB);

        // Reset held across two edges with changing inputs keeps outputs clear.
        step(1'b1, ones);
        chk_all("rst_hold1", z0);
        step(1'b1, mk(6'h11, 32'h1, 32'h2, 32'h3, 32'h4, 5'h06, 32'h7));
        chk_all("rst_hold2", z0);
        step(1'b0, mk(6'h11, 32'h1, 32'h2, 32'h3, 32'h4, 5'h06, 32'h7));
        chk_all("rst_release", mk(6'h11, 32'h1, 32'h2, 32'h3, 32'h4, 5'h06, 32'h7));

`ifdef MEM_WB_STALL_EN
        step(1'b0, mk(6'h20, 0, 0, 0, 0, 5'h01, 32'h1));
        chk("stall_pre", ReadDataOut, 32'h1);
        @(negedge Clk);
        Stall = 1'b1;
        ReadDataIn = 32'h2;
        RegWriteIn = 1'b0;
        @(posedge Clk);
        #1;
        chk("stall_hold_rd", ReadDataOut, 32'h1);
        chk("stall_hold_rw", {31'd0, RegWriteOut}, 32'd1);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        chk_all("stall_reset", z0);
        @(negedge Clk);
        Reset = 1'b0;
        Stall = 1'b0;
        @(posedge Clk);
        #1;
        chk("stall_release", ReadDataOut, 32'h2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
